// File: rtl/cnt_seq_ctrl_if.sv
// Control/status bundle for cnt_seq_ctrl: run request, run controls, run configuration
// and the observed counter/status outputs.
interface cnt_seq_ctrl_if #(
  parameter int W  = 4,
  parameter int PW = 3
);
  // Handshake: start is a level request with no ready. It is accepted only on an edge
  // where the controller is idle, and ignored otherwise. Configuration is captured on
  // that same edge. abort and pause are level controls that act only while busy.
  logic          start;
  logic          abort;
  logic          pause;
  logic [W-1:0]  start_val;
  logic [W-1:0]  end_val;
  logic          dir;
  logic [PW-1:0] div;
  logic [W-1:0]  cnt_qout;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  modport master (
    output start, abort, pause, start_val, end_val, dir, div,
    input  cnt_qout, busy, done, dbg_state
  );

  modport slave (
    input  start, abort, pause, start_val, end_val, dir, div,
    output cnt_qout, busy, done, dbg_state
  );
endinterface

// File: rtl/cnt_seq_ctrl.sv
// Prescaled up/down run counter. A run loads start_val, steps every div+1 clocks
// toward end_val with modulo-2^W arithmetic, and signals completion with a done pulse.
module cnt_seq_ctrl #(
  parameter int W  = 4,
  parameter int PW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  cnt_seq_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [W-1:0]  CNT_ONE = W'(1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);

  state_t        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d, cnt_step;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  sv_q, ev_q;
  logic          dir_q;
  logic [PW-1:0] div_q;
  logic          latch_cfg;
  logic          busy_q, done_q;

  assign cnt_step = dir_q ? (cnt_q + CNT_ONE) : (cnt_q - CNT_ONE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    latch_cfg = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          latch_cfg = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          cnt_d   = sv_q;
          presc_d = '0;
          state_d = (sv_q == ev_q) ? DONE : RUN;
        end
      end
      RUN: begin
        // abort beats pause, pause beats stepping
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!bus.pause) begin
          if (presc_q == div_q) begin
            presc_d = '0;
            cnt_d   = cnt_step;
            if (cnt_step == ev_q) state_d = DONE;
          end else begin
            presc_d = presc_q + PRE_ONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered decodes of the state, so they trail it by one clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      presc_q <= '0;
      sv_q    <= '0;
      ev_q    <= '0;
      dir_q   <= 1'b0;
      div_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      if (latch_cfg) begin
        sv_q  <= bus.start_val;
        ev_q  <= bus.end_val;
        dir_q <= bus.dir;
        div_q <= bus.div;
      end
      busy_q <= (state_q == LOAD) || (state_q == RUN);
      done_q <= (state_q == DONE);
    end
  end

  assign bus.cnt_qout  = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Self-checking bench for cnt_seq_ctrl: directed runs, pause/abort, reset and randomized runs
// checked edge by edge against an arithmetic model of the run timeline.
module tb_cnt_seq_ctrl;
  localparam int W  = 4;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cnt_seq_ctrl_if #(.W(W), .PW(PW)) bus ();

  cnt_seq_ctrl #(.W(W), .PW(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_cnt;
  logic [W-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_quiet();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pause = 1'b0;
  endtask

  // One run. The model: after edge e (e=1 is the load edge) the count is start +/- active/(div+1),
  // where active counts unpaused run edges; the run lasts N*(div+1) active edges.
  task automatic run_seq(input logic [W-1:0] sv, input logic [W-1:0] ev, input logic d,
                         input logic [PW-1:0] dv, input bit rnd, input int pause_at,
                         input int pause_len, input bit idle_after, input string tag);
    logic [W-1:0] diff;
    logic [W-1:0] want;
    int n, period, total, active;
    bit in_run, is_done_edge, pause_now, exp_busy, exp_done;
    diff   = d ? (ev - sv) : (sv - ev);
    n      = int'(diff);
    period = int'(dv) + 1;
    total  = n * period;
    active = 0;

    bus.start     = 1'b1;
    bus.abort     = 1'b0;
    bus.pause     = 1'b0;
    bus.start_val = sv;
    bus.end_val   = ev;
    bus.dir       = d;
    bus.div       = dv;
    exp_q.push_back(exp_cnt);
    tick();
    want = exp_q.pop_front();
    checks += 3;
    if (bus.cnt_qout !== want) begin
      failures++; $display("FAIL %s start_cnt got=%0d exp=%0d", tag, bus.cnt_qout, want);
    end
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL %s start_busy got=%0b exp=0", tag, bus.busy);
    end
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL %s start_done got=%0b exp=0", tag, bus.done);
    end

    for (int e = 1; e < 1000; e++) begin
      in_run       = (e >= 2) && (active < total);
      is_done_edge = (e >= 2) && !in_run;
      bus.start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.pause = 1'b0;
      if (in_run) begin
        pause_now = rnd ? ($urandom_range(0, 3) == 0) : (e >= pause_at && e < pause_at + pause_len);
        if (!pause_now) active++;
        bus.pause = pause_now;
      end else if (rnd) begin
        bus.pause = 1'($urandom_range(0, 1));
      end
      if (rnd) begin
        bus.start_val = W'($urandom);
        bus.end_val   = W'($urandom);
        bus.dir       = 1'($urandom);
        bus.div       = PW'($urandom);
      end
      exp_cnt  = d ? (sv + W'(active / period)) : (sv - W'(active / period));
      exp_busy = (e == 1) || in_run;
      exp_done = is_done_edge;
      exp_q.push_back(exp_cnt);
      tick();
      want = exp_q.pop_front();
      checks += 3;
      if (bus.cnt_qout !== want) begin
        failures++; $display("FAIL %s cnt e=%0d got=%0d exp=%0d", tag, e, bus.cnt_qout, want);
      end
      if (bus.busy !== exp_busy) begin
        failures++; $display("FAIL %s busy e=%0d got=%0b exp=%0b", tag, e, bus.busy, exp_busy);
      end
      if (bus.done !== exp_done) begin
        failures++; $display("FAIL %s done e=%0d got=%0b exp=%0b", tag, e, bus.done, exp_done);
      end
      if (is_done_edge) break;
    end
    drive_quiet();
    exp_cnt = ev;
    if (idle_after) begin
      tick();
      checks += 3;
      if (bus.cnt_qout !== ev) begin
        failures++; $display("FAIL %s idle_cnt got=%0d exp=%0d", tag, bus.cnt_qout, ev);
      end
      if (bus.busy !== 1'b0) begin
        failures++; $display("FAIL %s idle_busy got=%0b exp=0", tag, bus.busy);
      end
      if (bus.done !== 1'b0) begin
        failures++; $display("FAIL %s idle_done got=%0b exp=0", tag, bus.done);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_quiet();
    bus.start_val = '0;
    bus.end_val   = '0;
    bus.dir       = 1'b0;
    bus.div       = '0;
    tick();
    tick();
    exp_cnt = '0;
    checks += 3;
    if (bus.cnt_qout !== 4'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.cnt_qout);
    end
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy);
    end
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%0b exp=0", bus.done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_seq(4'd2, 4'd5, 1'b1, 3'd2, 1'b0, 0, 0, 1'b1, "up_run");
    run_seq(4'd1, 4'd14, 1'b0, 3'd0, 1'b0, 0, 0, 1'b1, "down_wrap");
    run_seq(4'd7, 4'd7, 1'b1, 3'd3, 1'b0, 0, 0, 1'b1, "equal");
    run_seq(4'd14, 4'd1, 1'b1, 3'd1, 1'b0, 0, 0, 1'b1, "up_wrap");
  endtask

  task automatic test_pause();
    run_seq(4'd3, 4'd9, 1'b1, 3'd1, 1'b0, 5, 4, 1'b1, "pause4");
  endtask

  task automatic test_abort();
    bus.start = 1'b1; bus.start_val = 4'd0; bus.end_val = 4'd10; bus.dir = 1'b1; bus.div = 3'd1;
    tick();
    drive_quiet();
    for (int i = 0; i < 7; i++) tick();
    exp_cnt = 4'd3;
    bus.abort = 1'b1;
    bus.pause = 1'b1;
    tick();
    checks += 2;
    if (bus.cnt_qout !== exp_cnt) begin
      failures++; $display("FAIL abort_cnt got=%0d exp=%0d", bus.cnt_qout, exp_cnt);
    end
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL abort_busy_lag got=%0b exp=1", bus.busy);
    end
    drive_quiet();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks += 3;
      if (bus.cnt_qout !== exp_cnt) begin
        failures++; $display("FAIL abort_hold_cnt i=%0d got=%0d exp=%0d", i, bus.cnt_qout, exp_cnt);
      end
      if (bus.busy !== 1'b0) begin
        failures++; $display("FAIL abort_busy i=%0d got=%0b exp=0", i, bus.busy);
      end
      if (bus.done !== 1'b0) begin
        failures++; $display("FAIL abort_done i=%0d got=%0b exp=0", i, bus.done);
      end
    end
  endtask

  task automatic test_reset_midrun();
    bus.start = 1'b1; bus.start_val = 4'd6; bus.end_val = 4'd12; bus.dir = 1'b1; bus.div = 3'd0;
    tick();
    drive_quiet();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.cnt_qout !== 4'd9) begin
      failures++; $display("FAIL midrun_cnt got=%0d exp=9", bus.cnt_qout);
    end
    rst_n = 1'b0;
    bus.start = 1'b1; bus.abort = 1'b1; bus.pause = 1'b1;
    tick();
    checks += 3;
    if (bus.cnt_qout !== 4'd0) begin
      failures++; $display("FAIL rst_mid_cnt got=%0d exp=0", bus.cnt_qout);
    end
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL rst_mid_busy got=%0b exp=0", bus.busy);
    end
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL rst_mid_done got=%0b exp=0", bus.done);
    end
    // start held high through release begins a run on the first released edge
    bus.abort = 1'b0; bus.pause = 1'b0;
    bus.start_val = 4'd5; bus.end_val = 4'd6; bus.dir = 1'b1; bus.div = 3'd0;
    rst_n = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks += 2;
    if (bus.cnt_qout !== 4'd5) begin
      failures++; $display("FAIL release_cnt got=%0d exp=5", bus.cnt_qout);
    end
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL release_busy got=%0b exp=1", bus.busy);
    end
    tick();
    tick();
    checks += 2;
    if (bus.done !== 1'b1) begin
      failures++; $display("FAIL release_done got=%0b exp=1", bus.done);
    end
    if (bus.cnt_qout !== 4'd6) begin
      failures++; $display("FAIL release_end got=%0d exp=6", bus.cnt_qout);
    end
    exp_cnt = 4'd6;
  endtask

  task automatic test_back_to_back();
    run_seq(4'd9, 4'd11, 1'b1, 3'd0, 1'b0, 0, 0, 1'b0, "b2b_a");
    run_seq(4'd3, 4'd0, 1'b0, 3'd1, 1'b0, 0, 0, 1'b1, "b2b_b");
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      run_seq(W'($urandom), W'($urandom), 1'($urandom), PW'($urandom_range(0, 3)),
              1'b1, 0, 0, 1'($urandom_range(0, 1)), "rand");
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_pause();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
